// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: default constants and the fetch FSM encoding.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetchState_t;

  // Wraps modulo 2^32; the low address bits are passed through untouched.
  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds while disabled, loads either a delivered instruction or a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcPlus4In,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= NOP_INSTR;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (en) begin
      if (clr) begin
        InstrD   <= NOP_INSTR;
        PCPlus4D <= 32'd0;
        ValidD   <= 1'b0;
      end else begin
        InstrD   <= instrIn;
        PCPlus4D <= pcPlus4In;
        ValidD   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, runs a single-outstanding imem handshake, and feeds IF/ID.
//   state | meaning
//   FETCH | request PCF when not stalled
//   WAIT  | request granted, waiting for imem_rvalid
//   HOLD  | response parked in skid buffer until decode unstalls
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic        JumpD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] PCF
);

  fetchState_t state, stateNext;
  logic [31:0] pcNext, fetchPc, fetchPcNext, bufInstr, bufPc;
  logic [31:0] delInstr, delPcPlus4, redirectTarget;
  logic        drop, dropNext, bufLoad, deliver, granted, redirect;

  assign imem_req       = !reset && (state == FETCH) && !StallF;
  assign imem_addr      = PCF;
  assign granted        = imem_req && imem_gnt;
  assign redirect       = !StallD && (PCSrcD || JumpD);
  assign redirectTarget = PCSrcD ? PCBranchD : PCJumpD;

  always_comb begin
    stateNext   = state;
    pcNext      = PCF;
    dropNext    = drop;
    fetchPcNext = fetchPc;
    bufLoad     = 1'b0;
    deliver     = 1'b0;
    delInstr    = imem_rdata;
    delPcPlus4  = pcPlus4(fetchPc);
    case (state)
      FETCH: if (granted) begin
        stateNext   = WAIT;
        fetchPcNext = PCF;
      end
      WAIT: if (imem_rvalid) begin
        if (drop) begin
          dropNext  = 1'b0;
          stateNext = FETCH;
        end else if (!StallD) begin
          deliver   = 1'b1;
          pcNext    = pcPlus4(fetchPc);
          stateNext = FETCH;
        end else begin
          bufLoad   = 1'b1;
          stateNext = HOLD;
        end
      end
      HOLD: if (!StallD) begin
        deliver    = 1'b1;
        delInstr   = bufInstr;
        delPcPlus4 = pcPlus4(bufPc);
        pcNext     = pcPlus4(bufPc);
        stateNext  = FETCH;
      end
      default: stateNext = FETCH;
    endcase
    // A response arriving in the redirect cycle is already consumed, so only a still-pending one is dropped.
    if (redirect) begin
      pcNext  = redirectTarget;
      deliver = 1'b0;
      if (granted || (state == WAIT && !imem_rvalid)) dropNext = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      PCF      <= RESET_PC;
      drop     <= 1'b0;
      fetchPc  <= RESET_PC;
      bufInstr <= NOP_INSTR;
      bufPc    <= 32'd0;
    end else begin
      state   <= stateNext;
      PCF     <= pcNext;
      drop    <= dropNext;
      fetchPc <= fetchPcNext;
      if (bufLoad) begin
        bufInstr <= imem_rdata;
        bufPc    <= fetchPc;
      end
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) uIfId (
    .clk       (clk),
    .reset     (reset),
    .en        (!StallD),
    .clr       (!deliver),
    .instrIn   (delInstr),
    .pcPlus4In (delPcPlus4),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  rvalidOnlyInWait: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> state == WAIT);

endmodule
